// File: rtl/mul_div_unit.sv
// mul_div_unit -- iterative integer multiply / divide unit with hi/lo result
// registers, in the style of a classic MIPS HI/LO multiplier-divider.
//
// One result bit is produced per clock, so every operation occupies exactly
// WIDTH RUN cycles. Signed operations run on operand magnitudes; the sign
// correction is folded into the final RUN cycle so it adds no latency.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   start  request a new operation (accepted in IDLE or DONE only)
//   op     00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b   multiplicand/dividend, multiplier/divisor (captured on accept)
//   wr_hi  direct write of hi from wdata (ignored while busy)
//   wr_lo  direct write of lo from wdata (ignored while busy)
//   wdata  data for wr_hi / wr_lo
//   busy   high exactly during the WIDTH RUN cycles
//   done   one-cycle pulse in the cycle after the result lands
//   hi     high product half / remainder
//   lo     low product half / quotient
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Counter must be able to hold the value WIDTH itself.
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement negate when neg is set, otherwise pass through.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                  input logic neg);
        return neg ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
    endfunction

    // Double-width variant used for the full product.
    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x,
                                                     input logic neg);
        return neg ? (~x + {{(2*WIDTH-1){1'b0}}, 1'b1}) : x;
    endfunction

    state_t             state_r;
    logic [CNT_W-1:0]   count_r;
    // work_r: multiply -> {partial product high, remaining multiplier bits}
    //         divide   -> {partial remainder, dividend bits / quotient bits}
    logic [2*WIDTH-1:0] work_r;
    // opnd_r: multiplicand magnitude (multiply) or divisor magnitude (divide)
    logic [WIDTH-1:0]   opnd_r;
    logic               is_div_r;
    logic               neg_a_r;   // dividend sign: sign of the remainder
    logic               neg_res_r; // sign(a) XOR sign(b): product / quotient sign
    logic               b_zero_r;

    logic               accept_s;
    logic               last_s;
    logic               signed_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH:0]     div_shift_s;
    logic               div_qbit_s;
    logic [WIDTH-1:0]   div_sub_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [2*WIDTH-1:0] work_next_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

    // Operand capture decode: acceptance, signedness and magnitudes.
    always_comb begin
        accept_s = start && (state_r != RUN);
        last_s   = (state_r == RUN) && (count_r == CNT_W'(1));
        signed_s = op[0];
        mag_a_s  = cond_neg(a, signed_s && a[WIDTH-1]);
        mag_b_s  = cond_neg(b, signed_s && b[WIDTH-1]);
    end

    // One iteration of shift-add multiply and restoring divide.
    always_comb begin
        // Multiply: add multiplicand into the high half when the current
        // multiplier bit is set, then shift the whole register right.
        if (work_r[0]) begin
            mul_sum_s = {1'b0, work_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
        end else begin
            mul_sum_s = {1'b0, work_r[2*WIDTH-1:WIDTH]};
        end
        mul_next_s = {mul_sum_s, work_r[WIDTH-1:1]};

        // Divide: shift the next dividend bit into the remainder and try a
        // subtraction. The true difference is below the divisor, so the low
        // WIDTH bits of a modular subtract are exact.
        div_shift_s = {work_r[2*WIDTH-1:WIDTH], work_r[WIDTH-1]};
        div_qbit_s  = (div_shift_s >= {1'b0, opnd_r});
        div_sub_s   = div_shift_s[WIDTH-1:0] - opnd_r;
        if (div_qbit_s) begin
            div_next_s = {div_sub_s, work_r[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {div_shift_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b0};
        end

        if (is_div_r) begin
            work_next_s = div_next_s;
        end else begin
            work_next_s = mul_next_s;
        end
    end

    // Final-cycle sign correction and divide-by-zero override.
    always_comb begin
        prod_s = cond_neg2(work_next_s, neg_res_r);
        if (is_div_r) begin
            // Remainder magnitude equals |a| when b is zero, so negating it
            // with the dividend sign returns a unchanged.
            res_hi_s = cond_neg(work_next_s[2*WIDTH-1:WIDTH], neg_a_r);
            if (b_zero_r) begin
                res_lo_s = {WIDTH{1'b1}};
            end else begin
                res_lo_s = cond_neg(work_next_s[WIDTH-1:0], neg_res_r);
            end
        end else begin
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Iterative datapath: operand capture on accept, one step per RUN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r   <= {CNT_W{1'b0}};
            work_r    <= {(2*WIDTH){1'b0}};
            opnd_r    <= {WIDTH{1'b0}};
            is_div_r  <= 1'b0;
            neg_a_r   <= 1'b0;
            neg_res_r <= 1'b0;
            b_zero_r  <= 1'b0;
        end else if (accept_s) begin
            count_r   <= CNT_W'(WIDTH);
            is_div_r  <= op[1];
            neg_a_r   <= signed_s && a[WIDTH-1];
            neg_res_r <= signed_s && (a[WIDTH-1] ^ b[WIDTH-1]);
            b_zero_r  <= (b == {WIDTH{1'b0}});
            if (op[1]) begin
                work_r <= {{WIDTH{1'b0}}, mag_a_s};
                opnd_r <= mag_b_s;
            end else begin
                work_r <= {{WIDTH{1'b0}}, mag_b_s};
                opnd_r <= mag_a_s;
            end
        end else if (state_r == RUN) begin
            count_r <= count_r - CNT_W'(1);
            work_r  <= work_next_s;
        end else begin
            count_r <= count_r;
            work_r  <= work_r;
        end
    end

    // Control FSM with registered busy/done and the architectural hi/lo.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= {WIDTH{1'b0}};
            lo      <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    // Direct writes land now; a started operation overwrites
                    // them when it completes.
                    if (wr_hi) begin
                        hi <= wdata;
                    end
                    if (wr_lo) begin
                        lo <= wdata;
                    end
                    done <= 1'b0;
                    if (start) begin
                        state_r <= RUN;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                RUN: begin
                    // Writes and start are ignored while running; hi/lo hold.
                    if (last_s) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        hi      <= res_hi_s;
                        lo      <= res_lo_s;
                    end else begin
                        state_r <= RUN;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH = 32): directed vectors from a
// table, hand-written multi-cycle sequences, and randomized operations
// compared with an arithmetic reference model.
module tb_mul_div_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          wr_hi;
    logic          wr_lo;
    logic [W-1:0]  wdata;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_seen <= done_seen + 1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the operation's meaning.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint q;
        longint r;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: res = {32'h0, x} * {32'h0, y};
            2'b01: res = sx * sy;
            2'b10: begin
                if (y == 32'h0) res = {x, 32'hFFFFFFFF};
                else res = {x % y, x / y};
            end
            default: begin
                if (y == 32'h0) res = {x, 32'hFFFFFFFF};
                else begin
                    q = sx / sy;   // truncates toward zero; 2^31 wraps to most-negative
                    r = sx % sy;   // takes the sign of the dividend
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // Count busy cycles starting at the current negedge until busy drops.
    task automatic wait_done(output int cycles);
        int guard;
        cycles = 0;
        guard  = 0;
        while (busy && guard < 100) begin
            cycles++;
            guard++;
            @(negedge clk);
        end
    endtask

    // Launch one operation from IDLE/DONE and return in its DONE cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        check("busy_cycles", cyc, 32);
        check("done_pulse", done, 1);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int cyc;
        int d0;
        logic [63:0] exp;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int mode;

        vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[4] = '{2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[5] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6] = '{2'b10, 32'h0000ABCD, 32'h00000000, 32'h0000ABCD, 32'hFFFFFFFF};
        vecs[7] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

        reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
        wr_hi = 1'b0; wr_lo = 1'b0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        reset = 1'b0;
        @(negedge clk);

        // Direct writes in IDLE.
        wr_lo = 1'b1; wdata = 32'h55;
        @(negedge clk);
        wr_lo = 1'b0;
        check("mtlo_idle", lo, 32'h55);
        wr_hi = 1'b1; wdata = 32'hAA;
        @(negedge clk);
        wr_hi = 1'b0;
        check("mthi_idle", hi, 32'hAA);

        // start and writes during RUN are ignored; hi/lo hold.
        start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        d0 = done_seen;
        start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd4;
        wr_lo = 1'b1; wr_hi = 1'b1; wdata = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; wr_lo = 1'b0; wr_hi = 1'b0;
        check("run_hold_hi", hi, 32'hAA);
        check("run_hold_lo", lo, 32'h55);
        wait_done(cyc);
        check("run_rest_cycles", cyc, 27);
        check("ignored_start_hi", hi, 32'd0);
        check("ignored_start_lo", lo, 32'd42);
        repeat (40) @(negedge clk);
        check("single_done", done_seen - d0, 1);

        // Write on the final RUN edge loses to the result.
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (31) @(negedge clk);
        wr_lo = 1'b1; wr_hi = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        wr_lo = 1'b0; wr_hi = 1'b0;
        check("final_edge_done", done, 1);
        check("final_edge_lo", lo, 32'd14);
        check("final_edge_hi", hi, 32'd2);

        // Back-to-back: start in the DONE cycle.
        start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_done_low", done, 0);
        wait_done(cyc);
        check("b2b_cycles", cyc, 32);
        check("b2b_hi", hi, 32'd0);
        check("b2b_lo", lo, 32'd6);

        // start together with a write: write lands, result overwrites later.
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd9; wr_lo = 1'b1; wdata = 32'h77;
        @(negedge clk);
        start = 1'b0; wr_lo = 1'b0;
        check("start_wr_lo", lo, 32'h77);
        check("start_wr_busy", busy, 1);
        wait_done(cyc);
        check("start_wr_cycles", cyc, 32);
        check("start_wr_result", lo, 32'd45);

        // Reset in RUN cycle 10 abandons the operation.
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        d0 = done_seen;
        reset = 1'b1;
        #1;
        check("rst_run_busy", busy, 0);
        check("rst_run_done", done, 0);
        check("rst_run_hi", hi, 0);
        check("rst_run_lo", lo, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_no_done", done_seen - d0, 0);

        // Directed vector table.
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
        end

        // Randomized operations against the reference model.
        for (int k = 0; k < 250; k++) begin
            ro   = 2'($urandom_range(0, 3));
            mode = $urandom_range(0, 7);
            ra   = $urandom;
            rb   = $urandom;
            if (mode == 0) rb = 32'h0;
            else if (mode == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            else if (mode == 2) rb = 32'($urandom_range(1, 15));
            else if (mode == 3) rb = -32'($urandom_range(1, 15));
            run_op(ro, ra, rb);
            exp = model(ro, ra, rb);
            check($sformatf("rand%0d_op%0d_hi", k, ro), hi, exp[63:32]);
            check($sformatf("rand%0d_op%0d_lo", k, ro), lo, exp[31:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width; legal range 4..64.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new operation.
REQ-005 SHALL have port op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port a  input  WIDTH  multiplicand / dividend.
REQ-007 SHALL have port b  input  WIDTH  multiplier / divisor.
REQ-008 SHALL have port wr_hi  input  1  direct write of hi (MTHI).
REQ-009 SHALL have port wr_lo  input  1  direct write of lo (MTLO).
REQ-010 SHALL have port wdata  input  WIDTH  data for wr_hi / wr_lo.
REQ-011 SHALL have port busy  output  1  operation in progress.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port hi  output  WIDTH  high product half / remainder.
REQ-014 SHALL have port lo  output  WIDTH  low product half / quotient.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; transitions as follows:
- IDLE->RUN on start.
- RUN->DONE after exactly WIDTH RUN cycles.
- DONE->RUN if start is high, else DONE->IDLE.
REQ-016 SHALL accept start only in IDLE or DONE; a, b, op SHALL be captured on the accepting edge. start in RUN SHALL be ignored.
REQ-017 busy SHALL be 1 exactly in RUN: for the WIDTH cycles following the accepting edge.
REQ-018 hi/lo SHALL update on the edge that ends the last RUN cycle; done SHALL be 1 for exactly the following cycle (DONE), with busy 0.
REQ-019 hi/lo SHALL hold their previous values throughout RUN; intermediate results SHALL live in internal registers only.
REQ-020 Datapath SHALL be iterative, one bit per cycle:
- Multiply: shift-add.
- Divide: restoring or non-restoring.
- Bit counter: ceil(log2(WIDTH+1)) bits.
REQ-021 MULTU/MULT SHALL produce {hi,lo} = full 2*WIDTH-bit product, unsigned or two's-complement respectively.
REQ-022 DIVU/DIV SHALL produce lo = quotient truncated toward zero, hi = remainder.
- Signed remainder carries the sign of the dividend.
- Signed quotient sign is sign(a) XOR sign(b).
REQ-023 Signed ops SHALL operate on magnitudes and apply sign correction in the final cycle, with no extra latency.
REQ-024 Divide by zero (b==0, DIVU or DIV) SHALL complete with normal latency: lo = all ones, hi = a.
REQ-025 DIV with a = most-negative and b = -1 SHALL yield lo = most-negative, hi = 0, with no error indication.
REQ-026 wr_hi/wr_lo SHALL write hi/lo at the edge when the FSM is in IDLE or DONE; they SHALL be ignored in RUN.
REQ-027 wr_hi/wr_lo on the same edge as a final-RUN result update SHALL lose; the result is written.
REQ-028 start together with wr_hi/wr_lo on the same edge SHALL perform both: the write lands now, and the result overwrites it at completion.

Reset
REQ-029 reset SHALL asynchronously force:
- FSM = IDLE, busy = 0, done = 0.
- hi = 0, lo = 0.
- counter and internal registers = 0.
REQ-030 reset asserted during RUN SHALL abandon the operation with no done pulse; the first start after release SHALL behave as from power-up.

Verification (WIDTH=32; accepting edge = E0)
REQ-031 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high for 32 cycles after E0; done high in cycle 33; hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 MULT a=-3 b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100 b=7 -> lo=14, hi=2.
REQ-033 DIV a=0x12345678 b=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 start (DIVU 9/4) pulsed at RUN cycle 5 of MULTU 6*7 -> ignored; result hi=0, lo=42; exactly one done pulse.
REQ-035 reset at RUN cycle 10 -> busy=0, done=0, hi=lo=0 immediately; no done pulse afterward.
REQ-036 Back-to-back:
- start MULTU 2*3 in the done cycle of a prior op -> busy next cycle; hi=0, lo=6 after 32 cycles.
- wr_lo=1, wdata=0x55 in IDLE -> lo=0x55 next cycle.
